// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with per-byte write enables and an optional output register.
// An optional clear sequencer zeroes every entry after reset, one address per cycle.
module sdp_ram_be #(
    parameter int    RAM_WIDTH      = 64,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    RAM_DEPTH      = 512,
    parameter int    READ_LATENCY   = 2,
    parameter string COLLISION      = "READ_FIRST",
    parameter int    CLEAR_ON_RESET = 1,
    localparam int   NB             = RAM_WIDTH / BYTE_WIDTH,
    localparam int   AW             = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 wea,
    input  logic [NB-1:0]        wbe,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [AW-1:0]        addrb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid,
    output logic                 init_busy
);

    localparam bit          WRITE_FIRST = (COLLISION == "WRITE_FIRST");
    localparam logic [AW:0] DEPTH_W     = (AW+1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "sdp_ram_be: READ_LATENCY must be 1 or 2");
        end
        if (COLLISION != "READ_FIRST" && COLLISION != "WRITE_FIRST") begin : g_bad_collision
            $fatal(1, "sdp_ram_be: COLLISION must be READ_FIRST or WRITE_FIRST");
        end
        if (RAM_WIDTH % BYTE_WIDTH != 0 || RAM_WIDTH < BYTE_WIDTH) begin : g_bad_width
            $fatal(1, "sdp_ram_be: RAM_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (RAM_DEPTH < 2) begin : g_bad_depth
            $fatal(1, "sdp_ram_be: RAM_DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  cnt_reg, cnt_next;
    logic           busy_reg, busy_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        // Reset wins over everything, which also restarts a clear already in progress.
        if (rstb) begin
            cnt_next   = '0;
            state_next = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
        end else begin
            case (state_reg)
                IDLE:  state_next = IDLE;
                CLEAR: begin
                    if (cnt_reg == LAST_ADDR) state_next = IDLE;
                    else                      cnt_next   = cnt_reg + 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
        busy_next = (state_next == CLEAR);
    end

    always_ff @(posedge clka) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        busy_reg  <= busy_next;
    end

    assign init_busy = (CLEAR_ON_RESET != 0) && busy_reg;

    logic                 addra_ok, addrb_ok;
    logic                 user_we, clr_we, rd_en, same_addr;
    logic [RAM_WIDTH-1:0] s1_data;
    logic                 v1_reg;

    assign addra_ok  = ({1'b0, addra} < DEPTH_W);
    assign addrb_ok  = ({1'b0, addrb} < DEPTH_W);
    assign user_we   = wea && !init_busy && !rstb && addra_ok;
    assign clr_we    = init_busy && !rstb;
    assign rd_en     = enb && !init_busy && !rstb;
    assign same_addr = (addra == addrb);

    // One narrow memory per byte lane, so every lane has a single writer and read port.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] mem [RAM_DEPTH];
            logic [BYTE_WIDTH-1:0] s1_reg;
            logic                  lane_we;

            assign lane_we = user_we && wbe[gi];

            always_ff @(posedge clka) begin
                if (clr_we)       mem[cnt_reg] <= '0;
                else if (lane_we) mem[addra]   <= dina[gi*BYTE_WIDTH +: BYTE_WIDTH];
            end

            always_ff @(posedge clka) begin
                if (rstb) begin
                    s1_reg <= '0;
                end else if (rd_en) begin
                    if (!addrb_ok)
                        s1_reg <= '0;
                    else if (WRITE_FIRST && lane_we && same_addr)
                        s1_reg <= dina[gi*BYTE_WIDTH +: BYTE_WIDTH];
                    else
                        s1_reg <= mem[addrb];
                end
            end

            assign s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = s1_reg;
        end
    endgenerate

    always_ff @(posedge clka) begin
        if (rstb) v1_reg <= 1'b0;
        else      v1_reg <= rd_en;
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic unused_regceb;
            assign unused_regceb = regceb;
            assign doutb         = s1_data;
            assign doutb_valid   = v1_reg;
        end else begin : g_lat2
            logic [RAM_WIDTH-1:0] dout_reg;
            logic                 dv_reg;

            // A stage-1 result that meets regceb=0 is dropped, never replayed later.
            always_ff @(posedge clka) begin
                if (rstb) begin
                    dout_reg <= '0;
                    dv_reg   <= 1'b0;
                end else if (regceb) begin
                    dout_reg <= s1_data;
                    dv_reg   <= v1_reg;
                end else begin
                    dv_reg   <= 1'b0;
                end
            end

            assign doutb       = dout_reg;
            assign doutb_valid = dv_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances (16-deep READ_FIRST latency 2, 10-deep WRITE_FIRST latency 1)
// share one stimulus stream and are checked against a word-level array model.
module tb_sdp_ram_be;
    localparam int W  = 64;
    localparam int NB = 8;
    localparam int AW = 4;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic          rstb, wea, enb, regceb;
    logic [NB-1:0] wbe;
    logic [AW-1:0] addra, addrb;
    logic [W-1:0]  dina;
    logic [W-1:0]  doutb_a, doutb_b;
    logic          dv_a, dv_b, busy_a, busy_b;

    sdp_ram_be #(.RAM_WIDTH(64), .BYTE_WIDTH(8), .RAM_DEPTH(16), .READ_LATENCY(2),
                 .COLLISION("READ_FIRST"), .CLEAR_ON_RESET(1)) dut_a (
        .clka(clka), .rstb(rstb), .wea(wea), .wbe(wbe), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .regceb(regceb), .doutb(doutb_a),
        .doutb_valid(dv_a), .init_busy(busy_a));

    sdp_ram_be #(.RAM_WIDTH(64), .BYTE_WIDTH(8), .RAM_DEPTH(10), .READ_LATENCY(1),
                 .COLLISION("WRITE_FIRST"), .CLEAR_ON_RESET(1)) dut_b (
        .clka(clka), .rstb(rstb), .wea(wea), .wbe(wbe), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .regceb(regceb), .doutb(doutb_b),
        .doutb_valid(dv_b), .init_busy(busy_b));

    // Reference model: whole-word arrays, clear countdowns and expected output state.
    logic [W-1:0] ma [16];
    logic [W-1:0] mb [16];
    int           ba_left = 0, bb_left = 0;
    logic [W-1:0] a_s1 = '0, a_out = '0, b_out = '0;
    logic         a_v1 = 1'b0, a_vout = 1'b0, b_vout = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                           input logic [NB-1:0] be);
        logic [W-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++)
            if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    // Apply one cycle of inputs, then advance the model by that cycle.
    task automatic step(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] aa,
                        input logic [W-1:0] d, input logic en, input logic [AW-1:0] ab,
                        input logic rce, input logic rst);
        logic [W-1:0] rd_b;
        wea = we; wbe = be; addra = aa; dina = d; enb = en; addrb = ab; regceb = rce; rstb = rst;
        @(posedge clka); #1;
        if (rst) begin
            a_s1 = '0; a_v1 = 1'b0; a_out = '0; a_vout = 1'b0; b_out = '0; b_vout = 1'b0;
            ba_left = 16; bb_left = 10;
            for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
        end else begin
            if (rce) begin a_out = a_s1; a_vout = a_v1; end
            else a_vout = 1'b0;
            a_v1 = en && (ba_left == 0);
            if (a_v1) a_s1 = ma[ab];
            b_vout = en && (bb_left == 0);
            if (b_vout) begin
                if (ab >= 10)                 rd_b = '0;
                else if (we && aa == ab)      rd_b = merge(mb[ab], d, be);
                else                          rd_b = mb[ab];
                b_out = rd_b;
            end
            if (we && ba_left == 0)            ma[aa] = merge(ma[aa], d, be);
            if (we && bb_left == 0 && aa < 10) mb[aa] = merge(mb[aa], d, be);
            if (ba_left > 0) ba_left--;
            if (bb_left > 0) bb_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        // Write and read pending in the reset cycle must be discarded.
        step(1'b1, '1, 4'd2, {16{4'hF}}, 1'b1, 4'd2, 1'b1, 1'b1);
        n_vec++; if (doutb_a !== '0)  begin n_err++; $display("FAIL reset_dout_a got %h exp 0", doutb_a); end
        n_vec++; if (dv_a !== 1'b0)   begin n_err++; $display("FAIL reset_dv_a got %b exp 0", dv_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy_a got %b exp 1", busy_a); end
        n_vec++; if (doutb_b !== '0)  begin n_err++; $display("FAIL reset_dout_b got %h exp 0", doutb_b); end
        n_vec++; if (dv_b !== 1'b0)   begin n_err++; $display("FAIL reset_dv_b got %b exp 0", dv_b); end
        n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL reset_busy_b got %b exp 1", busy_b); end
    endtask

    task automatic test_clear;
        int ca, cb;
        for (int k = 0; k < 40 && (busy_a || busy_b); k++) idle(1);
        n_vec++; if (busy_a !== 1'b0 || busy_b !== 1'b0)
            begin n_err++; $display("FAIL clear_wait busy_a=%b busy_b=%b exp 0 0", busy_a, busy_b); end
        for (int i = 0; i < 16; i++) step(1'b1, '1, 4'(i), '1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        ca = 0; cb = 0;
        for (int k = 0; k < 30; k++) begin
            ca += int'(busy_a); cb += int'(busy_b);
            n_vec++; if (busy_a !== (ba_left > 0) || busy_b !== (bb_left > 0))
                begin n_err++; $display("FAIL clear_busy cyc=%0d got %b%b exp %b%b", k, busy_a, busy_b, ba_left > 0, bb_left > 0); end
            idle(1);
        end
        n_vec++; if (ca != 16) begin n_err++; $display("FAIL clear_len_a got %0d exp 16", ca); end
        n_vec++; if (cb != 10) begin n_err++; $display("FAIL clear_len_b got %0d exp 10", cb); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 4'(i), 1'b1, 1'b0);
            n_vec++; if (doutb_b !== '0 || dv_b !== 1'b1)
                begin n_err++; $display("FAIL clear_rd_b addr=%0d got %h/%b exp 0/1", i, doutb_b, dv_b); end
            idle(1);
            n_vec++; if (doutb_a !== '0 || dv_a !== 1'b1)
                begin n_err++; $display("FAIL clear_rd_a addr=%0d got %h/%b exp 0/1", i, doutb_a, dv_a); end
        end
    endtask

    task automatic test_byte_enable;
        step(1'b1, 8'hFF, 4'd5, {16{4'h1}}, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h0F, 4'd5, {16{4'hA}}, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b1, 1'b0);
        n_vec++; if (doutb_b !== 64'h11111111AAAAAAAA || dv_b !== 1'b1)
            begin n_err++; $display("FAIL be_b got %h/%b exp 11111111aaaaaaaa/1", doutb_b, dv_b); end
        idle(1);
        n_vec++; if (doutb_a !== 64'h11111111AAAAAAAA || dv_a !== 1'b1)
            begin n_err++; $display("FAIL be_a got %h/%b exp 11111111aaaaaaaa/1", doutb_a, dv_a); end
        step(1'b1, 8'h00, 4'd5, '0, 1'b1, 4'd5, 1'b1, 1'b0);
        n_vec++; if (doutb_b !== 64'h11111111AAAAAAAA)
            begin n_err++; $display("FAIL be_none_b got %h exp 11111111aaaaaaaa", doutb_b); end
    endtask

    task automatic test_collision;
        step(1'b1, '1, 4'd3, 64'h5, 1'b1, 4'd3, 1'b1, 1'b0);
        n_vec++; if (doutb_b !== 64'h5 || dv_b !== 1'b1)
            begin n_err++; $display("FAIL coll_wf got %h/%b exp 5/1", doutb_b, dv_b); end
        idle(1);
        n_vec++; if (doutb_a !== 64'h0 || dv_a !== 1'b1)
            begin n_err++; $display("FAIL coll_rf got %h/%b exp 0/1", doutb_a, dv_a); end
        step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1, 1'b0);
        n_vec++; if (doutb_b !== 64'h5) begin n_err++; $display("FAIL coll_next_b got %h exp 5", doutb_b); end
        idle(1);
        n_vec++; if (doutb_a !== 64'h5) begin n_err++; $display("FAIL coll_next_a got %h exp 5", doutb_a); end
    endtask

    task automatic test_latency;
        idle(2);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b1, 1'b0);
        n_vec++; if (dv_a !== 1'b0) begin n_err++; $display("FAIL lat_t1 got %b exp 0", dv_a); end
        idle(1);
        n_vec++; if (dv_a !== 1'b1 || doutb_a !== 64'h11111111AAAAAAAA)
            begin n_err++; $display("FAIL lat_t2 got %h/%b exp 11111111aaaaaaaa/1", doutb_a, dv_a); end
        idle(1);
        n_vec++; if (dv_a !== 1'b0) begin n_err++; $display("FAIL lat_t3 got %b exp 0", dv_a); end
        step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_vec++; if (dv_a !== 1'b0 || doutb_a !== 64'h11111111AAAAAAAA)
            begin n_err++; $display("FAIL lat_hold got %h/%b exp 11111111aaaaaaaa/0", doutb_a, dv_a); end
        idle(1);
        n_vec++; if (dv_a !== 1'b0 || doutb_a !== a_out)
            begin n_err++; $display("FAIL lat_drop got %h/%b exp %h/0", doutb_a, dv_a, a_out); end
    endtask

    task automatic test_reset_mid_clear;
        int ca;
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle(7);
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL midclr_pre got %b exp 1", busy_a); end
        step(1'b1, '1, 4'd7, '1, 1'b0, '0, 1'b1, 1'b1);
        ca = 0;
        for (int k = 0; k < 20; k++) begin
            ca += int'(busy_a);
            step(k < 16, NB'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 1'b0, '0, 1'b1, 1'b0);
        end
        n_vec++; if (ca != 16) begin n_err++; $display("FAIL midclr_len got %0d exp 16", ca); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 4'(i), 1'b1, 1'b0);
            n_vec++; if (doutb_b !== ((i < 10) ? mb[i] : 64'h0))
                begin n_err++; $display("FAIL midclr_b addr=%0d got %h exp %h", i, doutb_b, (i < 10) ? mb[i] : 64'h0); end
            idle(1);
            n_vec++; if (doutb_a !== 64'h0)
                begin n_err++; $display("FAIL midclr_a addr=%0d got %h exp 0", i, doutb_a); end
        end
    endtask

    task automatic test_out_of_range;
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        step(1'b1, '1, 4'd12, v, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd12, 1'b1, 1'b0);
        n_vec++; if (doutb_b !== '0 || dv_b !== 1'b1)
            begin n_err++; $display("FAIL oor_b got %h/%b exp 0/1", doutb_b, dv_b); end
        idle(1);
        n_vec++; if (doutb_a !== v || dv_a !== 1'b1)
            begin n_err++; $display("FAIL oor_a got %h/%b exp %h/1", doutb_a, dv_a, v); end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 4'(i), 1'b1, 1'b0);
            n_vec++; if (doutb_b !== mb[i])
                begin n_err++; $display("FAIL oor_keep addr=%0d got %h exp %h", i, doutb_b, mb[i]); end
        end
    endtask

    task automatic test_back_to_back;
        idle(2);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) step(1'b0, '0, '0, '0, 1'b1, 4'(k), 1'b1, 1'b0);
            else       idle(1);
            n_vec++; if (dv_b !== (k < 8))
                begin n_err++; $display("FAIL b2b_b cyc=%0d got %b exp %b", k, dv_b, k < 8); end
            n_vec++; if (dv_a !== (k >= 1 && k < 9))
                begin n_err++; $display("FAIL b2b_a cyc=%0d got %b exp %b", k, dv_a, k >= 1 && k < 9); end
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] aa, ab;
        for (int k = 0; k < 300; k++) begin
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), NB'($urandom), aa, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, ab, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 149) == 0);
            n_vec++; if (doutb_a !== a_out || dv_a !== a_vout || busy_a !== (ba_left > 0))
                begin n_err++; $display("FAIL rand_a cyc=%0d got %h/%b/%b exp %h/%b/%b", k, doutb_a, dv_a, busy_a, a_out, a_vout, ba_left > 0); end
            n_vec++; if (doutb_b !== b_out || dv_b !== b_vout || busy_b !== (bb_left > 0))
                begin n_err++; $display("FAIL rand_b cyc=%0d got %h/%b/%b exp %h/%b/%b", k, doutb_b, dv_b, busy_b, b_out, b_vout, bb_left > 0); end
        end
    endtask

    initial begin
        rstb = 1'b0; wea = 1'b0; wbe = '0; addra = '0; dina = '0;
        enb = 1'b0; addrb = '0; regceb = 1'b0;
        for (int i = 0; i < 16; i++) begin ma[i] = '0; mb[i] = '0; end
        repeat (2) @(posedge clka);
        #1;
        test_reset;
        test_clear;
        test_byte_enable;
        test_collision;
        test_latency;
        test_reset_mid_clear;
        test_out_of_range;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdp_ram_be.md
SDP_RAM_BE -- requirements
Module: sdp_ram_be

Interface
REQ-001: The block SHALL have parameter RAM_WIDTH, default 64, data width in bits; it SHALL be a multiple of BYTE_WIDTH.
REQ-002: The block SHALL have parameter BYTE_WIDTH, default 8, write-lane width; NB = RAM_WIDTH/BYTE_WIDTH lanes.
REQ-003: The block SHALL have parameter RAM_DEPTH, default 512, number of entries (any value >= 2, not necessarily a power of two); AW = ceil(log2(RAM_DEPTH)).
REQ-004: The block SHALL have parameter READ_LATENCY, default 2, allowed values 1 or 2 only.
REQ-005: The block SHALL have parameter COLLISION, default "READ_FIRST", allowed values "READ_FIRST" or "WRITE_FIRST".
REQ-006: The block SHALL have parameter CLEAR_ON_RESET, default 1; when 1, reset zeroes the memory contents.
REQ-007: The block SHALL have port clka, input, 1 bit: single clock; all logic is on the rising edge.
REQ-008: The block SHALL have port rstb, input, 1 bit: reset, synchronous, active-high.
REQ-009: The block SHALL have port wea, input, 1 bit: write request.
REQ-010: The block SHALL have port wbe, input, NB bits: per-lane byte write enables.
REQ-011: The block SHALL have port addra, input, AW bits: write address.
REQ-012: The block SHALL have port dina, input, RAM_WIDTH bits: write data.
REQ-013: The block SHALL have port enb, input, 1 bit: read request.
REQ-014: The block SHALL have port addrb, input, AW bits: read address.
REQ-015: The block SHALL have port regceb, input, 1 bit: output-register enable; it is used only when READ_LATENCY=2.
REQ-016: The block SHALL have port doutb, output, RAM_WIDTH bits: read data.
REQ-017: The block SHALL have port doutb_valid, output, 1 bit: a 1-cycle pulse per delivered read.
REQ-018: The block SHALL have port init_busy, output, 1 bit: high while the clear sequence runs.

Function
REQ-019: Clear FSM states SHALL be IDLE and CLEAR; IDLE -> CLEAR on rstb=1 when CLEAR_ON_RESET=1; CLEAR -> IDLE on the cycle its counter writes address RAM_DEPTH-1.
REQ-020: In CLEAR, the block SHALL write all-zero data to one address per cycle, ascending from 0; a full clear takes exactly RAM_DEPTH cycles after rstb deasserts.
REQ-021: init_busy SHALL equal 1 exactly while the FSM is in CLEAR; it SHALL be registered.
REQ-022: rstb asserted during CLEAR SHALL restart the counter at 0.
REQ-023: With CLEAR_ON_RESET=0, memory contents SHALL be unaffected by rstb and init_busy SHALL be constant 0.
REQ-024: While init_busy=1, wea and enb SHALL be ignored: no user write, no read launched, and doutb_valid remains 0.
REQ-025: With wea=1 and init_busy=0, each lane i with wbe[i]=1 SHALL update bits [i*BYTE_WIDTH +: BYTE_WIDTH] at addra; lanes with wbe[i]=0 SHALL be unchanged; wbe all zero SHALL write nothing.
REQ-026: addra >= RAM_DEPTH SHALL write nothing; a read with addrb >= RAM_DEPTH SHALL return all zero and still pulse doutb_valid.
REQ-027: For stage 1 with enb=1 and init_busy=0, the block SHALL register the data at addrb and set v1=1; with enb=0, stage-1 data SHALL hold and v1=0.
REQ-028: On a collision (wea=1, enb=1, addra==addrb, same cycle), "READ_FIRST" SHALL return the pre-write word; "WRITE_FIRST" SHALL return the merged word, i.e. dina on enabled lanes and old data on the others.
REQ-029: With READ_LATENCY=1, doutb SHALL be the stage-1 register and doutb_valid = v1, i.e. data appears 1 cycle after enb; regceb is ignored.
REQ-030: With READ_LATENCY=2 and regceb=1, the output stage SHALL load doutb <= stage-1 data and doutb_valid <= v1, i.e. 2-cycle latency.
REQ-031: With READ_LATENCY=2 and regceb=0, doutb SHALL hold and doutb_valid SHALL be 0; a stage-1 result not captured is dropped.
REQ-032: Back-to-back reads, one per cycle, SHALL sustain full throughput, with doutb_valid high on consecutive cycles.
REQ-033: Illegal READ_LATENCY, COLLISION, or RAM_WIDTH % BYTE_WIDTH != 0 SHALL be detected at elaboration (fatal).

Reset
REQ-034: rstb=1 SHALL clear doutb, the stage-1 data register, v1 and doutb_valid to 0 on the next edge, independent of regceb.
REQ-035: After rstb, init_busy SHALL read 1 in the first cycle following the reset edge when CLEAR_ON_RESET=1, and 0 otherwise.
REQ-036: A write or read pending in the same cycle as rstb=1 SHALL be discarded.

Verification
REQ-037: Clear: RAM_DEPTH=16, CLEAR_ON_RESET=1; preload 0xFF.., pulse rstb -> init_busy high for exactly 16 cycles, then every address reads 0.
REQ-038: Byte enables: write 0x1111..11 to addr 5, then wbe=8'h0F with dina=0xAAAA..AA -> read of addr 5 returns 0x11111111AAAAAAAA.
REQ-039: Collision: addr 3 holds 0; same cycle wea=1, wbe=all, dina=0x5, enb=1, addrb=3 -> "READ_FIRST" returns 0 and "WRITE_FIRST" returns 0x5; the next read returns 0x5.
REQ-040: Latency: READ_LATENCY=2, regceb=1, enb pulsed at cycle t -> doutb_valid=1 at t+2 only; with regceb=0 at t+1, doutb_valid stays 0 and doutb holds.
REQ-041: Reset mid-clear: rstb reasserted at clear count 7 of 16 -> the counter restarts, init_busy lasts a further 16 cycles, and user writes during that window have no effect.
REQ-042: Non-power-of-two: RAM_DEPTH=10, write to addra=12 -> no address changes; a read of addrb=12 returns 0 with doutb_valid pulsed.
